// File: rtl/dmem_lsu_pkg.sv
// Shared types and lane helpers for the data-memory load/store unit.
package dmem_lsu_pkg;

  localparam int unsigned LSU_ADDR_W = 12;
  localparam int unsigned LSU_DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LD_WAIT = 2'd1,
    ST_RMW_WR  = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Replace the addressed lane(s) of word with the right-justified store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: r[{off, 3'b000} +: 8]     = data[7:0];
      SZ_HALF: r[{off[1], 4'b0000} +: 16] = data[15:0];
      default: r = data;
    endcase
    return r;
  endfunction

  // Pull the addressed lane out of word and sign- or zero-extend it.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lsu.sv
// Load/store initiator between execute and a word-wide synchronous data memory.
// Optional alignment checking is enabled by defining LSU_ALIGN_CHECK_EN.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W,
  parameter int unsigned DATA_W = LSU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_rena,
  output logic              mem_wena,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          size_eff_c;
  logic                misalign_c;

  assign size_eff_c = (size == SZ_RSVD) ? SZ_WORD : size;

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign_c = ((size == SZ_HALF) && addr[0])
                   || ((size == SZ_WORD) && (addr[1:0] != 2'b00))
                   || (size == SZ_RSVD);
`else
  assign misalign_c = 1'b0;
`endif

  // Next state, request latches and memory drive; IDLE uses live inputs.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    mem_rena  = 1'b0;
    mem_wena  = 1'b0;
    mem_addr  = addr_q[ADDR_W-1:2];
    mem_wdata = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        mem_addr  = addr[ADDR_W-1:2];
        mem_wdata = wdata;
        if (req) begin
          we_d    = we;
          size_d  = size_eff_c;
          uns_d   = uns;
          addr_d  = addr;
          wdata_d = wdata;
          if (misalign_c) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (we && (size_eff_c == SZ_WORD)) begin
            mem_wena = 1'b1;
            state_d  = ST_DONE;
          end else begin
            mem_rena = 1'b1;
            state_d  = we ? ST_RMW_WR : ST_LD_WAIT;
          end
        end
      end
      ST_LD_WAIT: begin
        if (!we_q) begin
          rdata_d = lane_extract(mem_rdata, size_q, addr_q[1:0], uns_q);
        end
        state_d = ST_DONE;
      end
      ST_RMW_WR: begin
        mem_wena  = 1'b1;
        mem_wdata = lane_merge(mem_rdata, wdata_q, size_q, addr_q[1:0]);
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset aborts the access: no memory strobe may escape in that cycle.
    if (rst) begin
      mem_rena = 1'b0;
      mem_wena = 1'b0;
    end

    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: synchronous word memory, transaction-level reference model, directed vectors.
module tb_dmem_lsu;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        mem_rena;
  logic        mem_wena;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_lsu dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .size      (size),
    .uns       (uns),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .mem_rena  (mem_rena),
    .mem_wena  (mem_wena),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Data memory: read data registered one cycle after mem_rena.
  logic [31:0] mem [1024];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else begin
      if (mem_rena) mem_rdata <= mem[mem_addr];
      if (mem_wena) mem[mem_addr] <= mem_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state (owned by the compare process).
  logic [31:0] ref_mem [1024];
  bit          busy = 1'b0;
  int          acc = 0;
  int          done_at = 0;
  bit          t_we, t_mis, t_rmw;
  logic [1:0]  t_sz, t_off;
  logic [9:0]  t_idx;
  logic [31:0] t_wdata, t_merged, t_result;
  logic [31:0] rdata_m = '0;
  int          n_acc = 0;
  int          n_fin = 0;
  int          dut_done_cnt = 0;
  int          dut_done_cyc = 0;
  bit          err_seen = 1'b0;
  logic [9:0]  acc_mem_addr = '0;

  // Literal checks posted by the stimulus process, executed by the compare process.
  int          lit_seq = 0;
  int          lit_done = 0;
  string       lit_name;
  logic [31:0] lit_act, lit_exp;

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                         input logic [1:0] off, input bit u);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = (w >> (8 * off)) & 32'h0000_00FF;
        if (!u && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (w >> (16 * off[1])) & 32'h0000_FFFF;
        if (!u && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] mask;
    case (sz)
      2'd0: begin
        mask = 32'h0000_00FF << (8 * off);
        return (w & ~mask) | ((d & 32'h0000_00FF) << (8 * off));
      end
      2'd1: begin
        mask = 32'h0000_FFFF << (16 * off[1]);
        return (w & ~mask) | ((d & 32'h0000_FFFF) << (16 * off[1]));
      end
      default: return d;
    endcase
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Single compare process: model prediction and DUT check every cycle.
  always @(negedge clk) begin
    bit          e_ready, e_done, e_ren, e_wen, acc_now;
    logic [9:0]  e_addr;
    logic [31:0] e_wd;
    if (cyc > 0) begin
      if (mem_clr) for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      e_ready = !busy;
      e_done  = busy && (cyc == done_at);
      e_ren   = 1'b0;
      e_wen   = 1'b0;
      e_addr  = '0;
      e_wd    = '0;
      acc_now = 1'b0;
      if (!rst && !busy && req) begin
        acc_now = 1'b1;
        acc     = cyc;
        n_acc++;
        t_we    = we;
        t_sz    = size;
        t_off   = addr[1:0];
        t_idx   = addr[11:2];
        t_wdata = wdata;
`ifdef LSU_ALIGN_CHECK_EN
        t_mis = ((size == 2'd1) && addr[0]) || ((size == 2'd2) && (addr[1:0] != 2'd0))
             || (size == 2'd3);
`else
        t_mis = 1'b0;
`endif
        if (t_sz == 2'd3) t_sz = 2'd2;
        t_rmw    = !t_mis && we && (t_sz != 2'd2);
        t_merged = m_store(ref_mem[t_idx], wdata, t_sz, t_off);
        t_result = m_load(ref_mem[t_idx], t_sz, t_off, uns);
        done_at  = cyc + ((t_mis || (we && t_sz == 2'd2)) ? 1 : 2);
        e_addr   = t_idx;
        e_wd     = wdata;
        if (!t_mis) begin
          if (we && t_sz == 2'd2) e_wen = 1'b1;
          else                    e_ren = 1'b1;
        end
        acc_mem_addr = mem_addr;
      end else if (!rst && busy && t_rmw && (cyc == acc + 1)) begin
        e_wen  = 1'b1;
        e_addr = t_idx;
        e_wd   = t_merged;
      end

      chk1("ready", ready, e_ready);
      chk1("done", done, e_done);
      chk1("err", err, e_done && t_mis);
      chk32("rdata", rdata, rdata_m);
      chk1("mem_rena", mem_rena, e_ren);
      chk1("mem_wena", mem_wena, e_wen);
      if (e_ren || e_wen) chk32("mem_addr", 32'(mem_addr), 32'(e_addr));
      if (e_wen) chk32("mem_wdata", mem_wdata, e_wd);
      if (e_done) begin
        chk32("mem_word", mem[t_idx], ref_mem[t_idx]);
        n_fin++;
      end
      if (lit_seq != lit_done) begin
        chk32(lit_name, lit_act, lit_exp);
        lit_done = lit_seq;
      end

      if (done === 1'b1) begin
        dut_done_cnt++;
        dut_done_cyc = cyc;
        if (err === 1'b1) err_seen = 1'b1;
      end

      if (rst) begin
        busy    = 1'b0;
        rdata_m = '0;
      end else begin
        if (acc_now) begin
          busy = 1'b1;
          if (!t_mis && t_we && t_sz == 2'd2) ref_mem[t_idx] = t_wdata;
        end
        if (busy && t_rmw && (cyc == acc + 1)) ref_mem[t_idx] = t_merged;
        if (busy && !t_we && !t_mis && (cyc == acc + 1)) rdata_m = t_result;
        if (busy && (cyc == done_at)) busy = 1'b0;
      end
    end
  end

  task automatic post(input string nm, input logic [31:0] act, input logic [31:0] exp);
    lit_name = nm;
    lit_act  = act;
    lit_exp  = exp;
    lit_seq++;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_acc(input int n0);
    for (int k = 0; k < 20 && n_acc == n0; k++) begin
      @(negedge clk);
      #1;
    end
    if (n_acc == n0) post("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && busy; k++) begin
      @(negedge clk);
      #1;
    end
    if (busy) post("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input bit w, input logic [1:0] sz, input bit u,
                     input logic [11:0] a, input logic [31:0] d);
    int n0;
    n0 = n_acc;
    @(posedge clk);
    #1;
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    wait_acc(n0);
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_idle();
  endtask

  initial begin
    int n0, d0;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0;
    addr = '0; wdata = '0; mem_clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    post("reset_ready", 32'(ready), 32'd1);
    post("reset_done", 32'(done), 32'd0);
    post("reset_err", 32'(err), 32'd0);
    post("reset_rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_clr = 1'b0;

    // Test 1: sign/zero-extended byte and half loads
    txn(1'b1, 2'd2, 1'b0, 12'h014, 32'h8899_AABB);
    txn(1'b0, 2'd0, 1'b0, 12'h016, 32'h0);
    post("lb_rdata", rdata, 32'hFFFF_FF99);
    post("lb_latency", 32'(dut_done_cyc - acc), 32'd2);
    txn(1'b0, 2'd0, 1'b1, 12'h016, 32'h0);
    post("lbu_rdata", rdata, 32'h0000_0099);
    txn(1'b0, 2'd1, 1'b0, 12'h016, 32'h0);
    post("lh_rdata", rdata, 32'hFFFF_8899);
    txn(1'b0, 2'd1, 1'b1, 12'h014, 32'h0);
    txn(1'b0, 2'd0, 1'b0, 12'h014, 32'h0);
    txn(1'b0, 2'd0, 1'b1, 12'h017, 32'h0);

    // Test 2: half store is read-modify-write
    txn(1'b1, 2'd1, 1'b0, 12'h016, 32'h0000_1234);
    post("sh_word", mem[5], 32'h1234_AABB);
    post("sh_latency", 32'(dut_done_cyc - acc), 32'd2);
    post("sh_rdata_kept", rdata, 32'h8888_8888 & 32'h0 | 32'h0000_0088);
    txn(1'b1, 2'd0, 1'b0, 12'h015, 32'hFFFF_FFCC);

    // Test 3: word store and readback
    txn(1'b1, 2'd2, 1'b0, 12'h020, 32'hDEAD_BEEF);
    post("sw_mem_addr", 32'(acc_mem_addr), 32'h008);
    post("sw_latency", 32'(dut_done_cyc - acc), 32'd1);
    txn(1'b0, 2'd2, 1'b0, 12'h020, 32'h0);
    post("lw_rdata", rdata, 32'hDEAD_BEEF);

    // Test 4: reset during the write cycle of a byte store
    txn(1'b1, 2'd2, 1'b0, 12'h01C, 32'h1122_3344);
    n0 = n_acc;
    @(posedge clk);
    #1;
    req = 1'b1; we = 1'b1; size = 2'd0; uns = 1'b0; addr = 12'h01D; wdata = 32'h0000_00EE;
    wait_acc(n0);
    @(posedge clk);
    #1;
    req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    post("rst_ready", 32'(ready), 32'd1);
    post("rst_word_kept", mem[7], 32'h1122_3344);
    post("rst_rdata", rdata, 32'h0);

    // Test 5: back-to-back requests with req held high
    d0 = dut_done_cnt;
    n0 = n_acc;
    @(posedge clk);
    #1;
    req = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0; addr = 12'h020; wdata = 32'h0;
    wait_acc(n0);
    @(posedge clk);
    #1;
    we = 1'b1; size = 2'd0; addr = 12'h022; wdata = 32'h0000_0055;
    n0 = n_acc;
    wait_acc(n0);
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    post("b2b_dones", 32'(dut_done_cnt - d0), 32'd2);
    post("b2b_word", mem[8], 32'hDE55_BEEF);
    post("b2b_rdata", rdata, 32'hDEAD_BEEF);

    // Test 6: unaligned word load and reserved size
    txn(1'b1, 2'd2, 1'b0, 12'h000, 32'hCAFE_F00D);
    err_seen = 1'b0;
    txn(1'b0, 2'd2, 1'b0, 12'h002, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    post("misalign_err", 32'(err_seen), 32'd1);
    post("misalign_latency", 32'(dut_done_cyc - acc), 32'd1);
    post("misalign_rdata", rdata, 32'hDEAD_BEEF);
`else
    post("unaligned_lw", rdata, 32'hCAFE_F00D);
    post("unaligned_err", 32'(err_seen), 32'd0);
`endif
    txn(1'b0, 2'd3, 1'b0, 12'h020, 32'h0);

    // Byte lanes across one word, then half loads of both signs
    for (int k = 0; k < 4; k++) txn(1'b1, 2'd0, 1'b0, 12'h024 + 12'(k), 32'h10 + k);
    txn(1'b0, 2'd2, 1'b0, 12'h024, 32'h0);
    post("byte_lanes", rdata, 32'h1312_1110);
    txn(1'b1, 2'd2, 1'b0, 12'h028, 32'h8001_7FFF);
    txn(1'b0, 2'd1, 1'b0, 12'h02A, 32'h0);
    post("lh_upper_neg", rdata, 32'hFFFF_8001);
    txn(1'b0, 2'd1, 1'b1, 12'h02A, 32'h0);
    txn(1'b0, 2'd1, 1'b0, 12'h028, 32'h0);
    post("lh_lower_pos", rdata, 32'h0000_7FFF);

    repeat (2) @(negedge clk);
    post("done_count", 32'(dut_done_cnt), 32'(n_fin));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
